// File: rtl/bidir_xcvr_pkg.sv
// Shared definitions for the bidirectional transceiver: mode encodings,
// turnaround counter width and the request decode helper.
`timescale 1ns/1ps
package bidir_xcvr_pkg;

    typedef enum logic [1:0] {
        MODE_HIZ  = 2'b00,
        MODE_AB   = 2'b01,
        MODE_BA   = 2'b10,
        MODE_TURN = 2'b11
    } mode_t;

    localparam int TURN_CNT_W = 4;

    // Mode requested by the current en/dir inputs.
    function automatic mode_t target_mode(input logic en, input logic dir);
        if (!en) begin
            return MODE_HIZ;
        end
        return dir ? MODE_BA : MODE_AB;
    endfunction

endpackage

// File: rtl/bidir_xcvr_ctrl.sv
// Direction controller: HIZ/AB/BA/TURN state machine with a turnaround
// counter. A drive mode is only ever entered through TURN (or held), so the
// two output enables can never be asserted together.
`timescale 1ns/1ps
module bidir_xcvr_ctrl
    import bidir_xcvr_pkg::*;
#(
    parameter int TURN_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       dir,
    output logic       oe_a,
    output logic       oe_b,
    output logic [1:0] mode
);

    localparam logic [TURN_CNT_W-1:0] CNT_LAST = TURN_CNT_W'(TURN_CYCLES - 1);

    mode_t                 state_reg, state_next;
    mode_t                 tgt_reg, tgt_next;
    logic [TURN_CNT_W-1:0] cnt_reg, cnt_next;
    mode_t                 req;

    assign req = target_mode(en, dir);

    // State, latched target and turnaround counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= MODE_HIZ;
            tgt_reg   <= MODE_HIZ;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            tgt_reg   <= tgt_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: every entry into a drive mode passes through TURN.
    always_comb begin
        state_next = state_reg;
        tgt_next   = tgt_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            MODE_HIZ: begin
                if (req != MODE_HIZ) begin
                    state_next = MODE_TURN;
                    tgt_next   = req;
                    cnt_next   = '0;
                end
            end
            MODE_AB, MODE_BA: begin
                if (req == MODE_HIZ) begin
                    state_next = MODE_HIZ;
                    tgt_next   = MODE_HIZ;
                end else if (req != state_reg) begin
                    state_next = MODE_TURN;
                    tgt_next   = req;
                    cnt_next   = '0;
                end
            end
            MODE_TURN: begin
                if (req == MODE_HIZ) begin
                    state_next = MODE_HIZ;
                    tgt_next   = MODE_HIZ;
                    cnt_next   = '0;
                end else if (req != tgt_reg) begin
                    // Direction flipped mid-turn: retarget and start over.
                    tgt_next = req;
                    cnt_next = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = tgt_reg;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = MODE_HIZ;
                tgt_next   = MODE_HIZ;
                cnt_next   = '0;
            end
        endcase
    end

    // Output decode straight from the registered state.
    always_comb begin
        oe_a = (state_reg == MODE_BA);
        oe_b = (state_reg == MODE_AB);
        mode = state_reg;
    end

endmodule

// File: rtl/bidir_xcvr.sv
// Bidirectional transceiver top: tri-state drivers plus the data path.
// Define BIDIR_XCVR_REG_EN to drive from a register sampled every cycle
// (1-cycle latency, reset to 0); otherwise the driven value is a direct
// combinational copy of the source port.
`timescale 1ns/1ps
module bidir_xcvr
    import bidir_xcvr_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire [WIDTH-1:0]  port_a,
    inout  wire [WIDTH-1:0]  port_b,
    input  logic             en,
    input  logic             dir,
    output logic [1:0]       mode,
    output logic             busy
);

    logic             oe_a;
    logic             oe_b;
    logic [WIDTH-1:0] drv_ab;
    logic [WIDTH-1:0] drv_ba;

    bidir_xcvr_ctrl #(
        .TURN_CYCLES(TURN_CYCLES)
    ) u_ctrl (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .dir (dir),
        .oe_a(oe_a),
        .oe_b(oe_b),
        .mode(mode)
    );

    assign busy = (mode == MODE_TURN);

`ifdef BIDIR_XCVR_REG_EN
    logic [WIDTH-1:0] data_ab_reg;
    logic [WIDTH-1:0] data_ba_reg;

    // Sample both source ports every cycle; the enables pick which one is used.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_ab_reg <= '0;
            data_ba_reg <= '0;
        end else begin
            data_ab_reg <= port_a;
            data_ba_reg <= port_b;
        end
    end

    assign drv_ab = data_ab_reg;
    assign drv_ba = data_ba_reg;
`else
    assign drv_ab = port_a;
    assign drv_ba = port_b;
`endif

    assign port_b = oe_b ? drv_ab : {WIDTH{1'bz}};
    assign port_a = oe_a ? drv_ba : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bidir_xcvr.sv
// Self-checking bench for bidir_xcvr (WIDTH=8, TURN_CYCLES=2): directed
// scenarios plus a random en/dir/rst run against a behavioural model.
`timescale 1ns/1ps
module tb_bidir_xcvr;

    localparam int WIDTH       = 8;
    localparam int TURN_CYCLES = 2;
`ifdef BIDIR_XCVR_REG_EN
    localparam bit REG = 1'b1;
`else
    localparam bit REG = 1'b0;
`endif

    // {mode, busy, oe_a, oe_b}
    localparam logic [4:0] S_HIZ  = 5'b00_0_0_0;
    localparam logic [4:0] S_AB   = 5'b01_0_0_1;
    localparam logic [4:0] S_BA   = 5'b10_0_1_0;
    localparam logic [4:0] S_TURN = 5'b11_1_0_0;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en  = 1'b0;
    logic             dir = 1'b0;
    logic [1:0]       mode;
    logic             busy;
    wire  [WIDTH-1:0] port_a;
    wire  [WIDTH-1:0] port_b;
    logic             a_oe = 1'b0;
    logic             b_oe = 1'b0;
    logic [WIDTH-1:0] a_val = '0;
    logic [WIDTH-1:0] b_val = '0;
    int               errors = 0;
    int               checks = 0;
    logic [4:0]       st;

    assign port_a = a_oe ? a_val : {WIDTH{1'bz}};
    assign port_b = b_oe ? b_val : {WIDTH{1'bz}};
    assign st     = {mode, busy, dut.oe_a, dut.oe_b};

    bidir_xcvr #(
        .WIDTH(WIDTH),
        .TURN_CYCLES(TURN_CYCLES)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .port_a(port_a),
        .port_b(port_b),
        .en    (en),
        .dir   (dir),
        .mode  (mode),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; dir = 1'b0; a_oe = 1'b0; b_oe = 1'b0;
        tick();
        checks++; if (st !== S_HIZ) begin errors++; $display("FAIL rst_state: got %b want %b", st, S_HIZ); end
        en = 1'b1;
        tick();
        checks++; if (st !== S_HIZ) begin errors++; $display("FAIL rst_hold: got %b want %b", st, S_HIZ); end
        $display("test_reset done");
    endtask

    task automatic test_ab();
        rst = 1'b0; en = 1'b1; dir = 1'b0; a_oe = 1'b1; a_val = 8'hA5; b_oe = 1'b0;
        tick();
        checks++; if (st !== S_TURN) begin errors++; $display("FAIL ab_turn1: got %b want %b", st, S_TURN); end
        tick();
        checks++; if (st !== S_TURN) begin errors++; $display("FAIL ab_turn2: got %b want %b", st, S_TURN); end
        tick();
        checks++; if (st !== S_AB) begin errors++; $display("FAIL ab_mode: got %b want %b", st, S_AB); end
        checks++; if (port_b !== 8'hA5) begin errors++; $display("FAIL ab_data: port_b=%h want a5", port_b); end
        a_val = 8'h5A;
        #1;
        checks++; if (port_b !== (REG ? 8'hA5 : 8'h5A)) begin errors++; $display("FAIL ab_latency: port_b=%h want %h", port_b, REG ? 8'hA5 : 8'h5A); end
        tick();
        checks++; if (port_b !== 8'h5A) begin errors++; $display("FAIL ab_data2: port_b=%h want 5a", port_b); end
        $display("test_ab done");
    endtask

    task automatic test_dir_switch();
        dir = 1'b1;
        tick();
        checks++; if (st !== S_TURN) begin errors++; $display("FAIL ba_turn1: got %b want %b", st, S_TURN); end
        a_oe = 1'b0; b_oe = 1'b1; b_val = 8'h3C;
        tick();
        checks++; if (st !== S_TURN) begin errors++; $display("FAIL ba_turn2: got %b want %b", st, S_TURN); end
        tick();
        checks++; if (st !== S_BA) begin errors++; $display("FAIL ba_mode: got %b want %b", st, S_BA); end
        checks++; if (port_a !== 8'h3C) begin errors++; $display("FAIL ba_data: port_a=%h want 3c", port_a); end
        $display("test_dir_switch done");
    endtask

    task automatic test_disable();
        en = 1'b0;
        tick();
        checks++; if (st !== S_HIZ) begin errors++; $display("FAIL dis_mode: got %b want %b", st, S_HIZ); end
        a_oe = 1'b1; a_val = 8'h11;
        tick();
        checks++; if (st !== S_HIZ) begin errors++; $display("FAIL dis_hold: got %b want %b", st, S_HIZ); end
        $display("test_disable done");
    endtask

    task automatic test_turn_restart();
        b_oe = 1'b0; a_oe = 1'b1; a_val = 8'hC3;
        en = 1'b1; dir = 1'b1;
        tick();
        checks++; if (st !== S_TURN) begin errors++; $display("FAIL rs_t0: got %b want %b", st, S_TURN); end
        dir = 1'b0;
        tick();
        checks++; if (st !== S_TURN) begin errors++; $display("FAIL rs_t1: got %b want %b", st, S_TURN); end
        tick();
        checks++; if (st !== S_TURN) begin errors++; $display("FAIL rs_t2: got %b want %b", st, S_TURN); end
        tick();
        checks++; if (st !== S_AB) begin errors++; $display("FAIL rs_ab: got %b want %b", st, S_AB); end
        checks++; if (port_b !== 8'hC3) begin errors++; $display("FAIL rs_data: port_b=%h want c3", port_b); end
        $display("test_turn_restart done");
    endtask

    task automatic test_reset_mid_turn();
        dir = 1'b1;
        tick();
        checks++; if (st !== S_TURN) begin errors++; $display("FAIL rm_turn: got %b want %b", st, S_TURN); end
        a_oe = 1'b0; b_oe = 1'b1; b_val = 8'hE7;
        rst = 1'b1;
        tick();
        checks++; if (st !== S_HIZ) begin errors++; $display("FAIL rm_hiz: got %b want %b", st, S_HIZ); end
        rst = 1'b0;
        tick();
        checks++; if (st !== S_TURN) begin errors++; $display("FAIL rm_t1: got %b want %b", st, S_TURN); end
        tick();
        checks++; if (st !== S_TURN) begin errors++; $display("FAIL rm_t2: got %b want %b", st, S_TURN); end
        tick();
        checks++; if (st !== S_BA) begin errors++; $display("FAIL rm_ba: got %b want %b", st, S_BA); end
        checks++; if (port_a !== 8'hE7) begin errors++; $display("FAIL rm_data: port_a=%h want e7", port_a); end
        $display("test_reset_mid_turn done");
    endtask

    // Model: m = 0 HIZ, 1 AB, 2 BA, 3 TURN; pend = mode to enter after the
    // turn; left = turn cycles still to elapse.
    task automatic test_random();
        int m, pend, left, tgt;
        logic [4:0]       exp_st;
        logic [WIDTH-1:0] pa, pb;
        rst = 1'b1; en = 1'b0; dir = 1'b0; a_oe = 1'b0; b_oe = 1'b0;
        tick();
        m = 0; pend = 0; left = 0; pa = '0; pb = '0;
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            en  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) dir = ~dir;
            a_val = WIDTH'($urandom);
            b_val = WIDTH'($urandom);
            a_oe  = (m != 2);
            b_oe  = (m != 1);
            @(negedge clk);
            exp_st = (m == 0) ? S_HIZ : (m == 1) ? S_AB : (m == 2) ? S_BA : S_TURN;
            checks++; if (st !== exp_st) begin errors++; $display("FAIL rnd_state[%0d]: got %b want %b", i, st, exp_st); end
            checks++; if (dut.oe_a === 1'b1 && dut.oe_b === 1'b1) begin errors++; $display("FAIL rnd_contention[%0d]: oe_a=1 oe_b=1 want not both", i); end
            if (m == 1) begin
                checks++; if (port_b !== (REG ? pa : a_val)) begin errors++; $display("FAIL rnd_ab_data[%0d]: port_b=%h want %h", i, port_b, REG ? pa : a_val); end
            end
            if (m == 2) begin
                checks++; if (port_a !== (REG ? pb : b_val)) begin errors++; $display("FAIL rnd_ba_data[%0d]: port_a=%h want %h", i, port_a, REG ? pb : b_val); end
            end
            @(posedge clk);
            pa  = a_val;
            pb  = b_val;
            tgt = !en ? 0 : (dir ? 2 : 1);
            if (rst) begin
                m = 0; pend = 0; left = 0;
            end else if (m == 3) begin
                if (tgt == 0) begin
                    m = 0;
                end else if (tgt != pend) begin
                    pend = tgt; left = TURN_CYCLES;
                end else begin
                    left--;
                    if (left == 0) m = pend;
                end
            end else if (tgt != m) begin
                if (tgt == 0) begin
                    m = 0;
                end else begin
                    m = 3; pend = tgt; left = TURN_CYCLES;
                end
            end
            #1;
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_ab();
        test_dir_switch();
        test_disable();
        test_turn_restart();
        test_reset_mid_turn();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
